pc_sp_unit: RTL and testbench
=============================

Name: pc_sp_unit

Overview:
Program-counter and stack-pointer register block of the multicycle datapath. It is driven directly by the control FSM outputs PCWrite, PCWriteCond, PCSrc, PCMUX, SPWrite and IRWrite. It holds PC, SP, the ALUOut register and the fetched-PC copy, and supplies them to the memory address mux and the ALU input muxes. Stack over/underflow and misaligned-target detection are handled here.

Parameters:
DATA_W, 16, datapath and address width.
RESET_PC, 16'h0000, PC value after reset.
SP_TOP, 16'hFFFE, SP value after reset (empty stack).
SP_LIMIT, 16'hF000, lowest legal SP; a push at this value overflows.
EXC_VEC, 16'h0010, target used when PCSrc=11.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
PCWrite  in  1  unconditional PC update enable
PCWriteCond  in  1  PC update enable qualified by zero
PCSrc  in  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 EXC_VEC
PCMUX  in  1  1 = next PC from mem_rdata (return), overrides PCSrc
SPWrite  in  1  SP update enable
sp_push  in  1  with SPWrite: 1 = SP-2 (push), 0 = SP+2 (pop)
IRWrite  in  1  instruction fetch strobe; captures pc into fetch_pc
zero  in  1  ALU zero flag
alu_result  in  DATA_W  combinational ALU output
mem_rdata  in  DATA_W  memory read data
ir_imm12  in  12  jump field of the instruction register
pc  out  DATA_W  current PC
sp  out  DATA_W  current SP
alu_out  out  DATA_W  ALUOut register
fetch_pc  out  DATA_W  PC of the instruction being executed
stack_ovf  out  1  sticky push-overflow flag
stack_unf  out  1  sticky pop-underflow flag
pc_misalign  out  1  one-cycle pulse on an odd PC target

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_PC, sp=SP_TOP, alu_out=0, fetch_pc=RESET_PC, stack_ovf=0, stack_unf=0, pc_misalign=0. Reset has priority over every other input, including mid-sequence.
- alu_out is loaded with alu_result on every clock edge. It always holds the previous cycle's ALU result.
- fetch_pc is loaded with the current pc on an edge where IRWrite=1.
- pc_en = PCWrite | (PCWriteCond & zero). When pc_en=0, pc holds.
- Target selection:
  - When PCMUX=1, the target is mem_rdata.
  - When PCMUX=0, the target comes from PCSrc: 00 alu_result; 01 alu_out; 10 {fetch_pc[15:13], ir_imm12, 1'b0}; 11 EXC_VEC.
- When pc_en=1, pc is loaded with the target with bit0 forced to 0. If target bit0 was 1, pc_misalign=1 for exactly that cycle; otherwise it is 0.
- Push (SPWrite=1, sp_push=1):
  - sp != SP_LIMIT: sp = sp-2.
  - sp == SP_LIMIT: sp holds and stack_ovf sets.
- Pop (SPWrite=1, sp_push=0):
  - sp != SP_TOP: sp = sp+2.
  - sp == SP_TOP: sp holds and stack_unf sets.
- stack_ovf and stack_unf clear only on rst.
- SP arithmetic is modulo 2^DATA_W. Wrap is unreachable because of the SP_LIMIT and SP_TOP guards.
- PC and SP updates are independent. Simultaneous PCWrite and SPWrite both take effect in the same edge; this is how call/return sequences are issued.
- PCWriteCond=1 with PCWrite=1 behaves as an unconditional write.
- All outputs are registered; latency from enable to new value is one edge. No internal FSM; all sequencing is owned by the control FSM.

Decomposition:
- Shared package: PCSrc encodings (PCSRC_ALU=2'b00, PCSRC_ALUOUT=2'b01, PCSRC_JUMP=2'b10, PCSRC_EXC=2'b11), DATA_W, and the reset constants. These are shared with the control FSM.
- Sub-module sp_guard: SP register plus the limit compare and sticky flags. The PC path stays in the top level.

Test Plan:
1. Reset then fetch: rst high 1 edge; PCWrite=1, PCSrc=00, alu_result=0x0002 -> pc=0x0002, sp=0xFFFE, all flags 0.
2. Conditional branch: alu_out=0x0040 (alu_result=0x0040 the edge before); PCWriteCond=1, PCSrc=01. With zero=0 -> pc unchanged. With zero=1 -> pc=0x0040.
3. Jump with misaligned field: fetch_pc=0x2000, ir_imm12=0x7FF, PCSrc=10 -> pc=0x2FFE. Check the misalign path separately: alu_result=0x0031, PCSrc=00 -> pc=0x0030, pc_misalign high exactly 1 cycle.
4. Call/return: SPWrite=1, sp_push=1 together with PCWrite=1, PCSrc=10 -> sp=0xFFFC and pc=jump target in the same edge. Then PCMUX=1, mem_rdata=0x0102, PCWrite=1, SPWrite=1, sp_push=0 -> pc=0x0102, sp=0xFFFE.
5. Stack bounds:
   - Pop at sp=0xFFFE -> sp stays 0xFFFE, stack_unf=1, and it stays set through later valid pushes.
   - Force 0x07FF pushes -> sp=0xF000. The next push leaves sp=0xF000 and sets stack_ovf=1.
6. Reset mid-operation: rst=1 on the same edge as PCWrite=1, SPWrite=1 and IRWrite=1 -> all outputs return to reset values and the flags clear.

Source files
------------

// File: rtl/pc_sp_unit_pkg.sv
// Constants and PC source encodings shared by the PC/SP block and the control FSM.
package pc_sp_unit_pkg;

  localparam int          DATA_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam logic [15:0] SP_TOP   = 16'hFFFE;
  localparam logic [15:0] SP_LIMIT = 16'hF000;
  localparam logic [15:0] EXC_VEC  = 16'h0010;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_EXC    = 2'b11
  } pcsrc_e;

endpackage

// File: rtl/pc_sp_unit_sp_guard.sv
// Stack pointer with limit/top guards and sticky over/underflow flags.
// Latency: one edge from SPWrite to new sp/flags; no backpressure.
module sp_guard #(
  parameter int                 DATA_W   = pc_sp_unit_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  SP_TOP   = pc_sp_unit_pkg::SP_TOP,
  parameter logic [DATA_W-1:0]  SP_LIMIT = pc_sp_unit_pkg::SP_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sp_write,
  input  logic              sp_push,
  output logic [DATA_W-1:0] sp,
  output logic              stack_ovf,
  output logic              stack_unf
);

  logic at_limit;
  logic at_top;

  assign at_limit = (sp == SP_LIMIT);
  assign at_top   = (sp == SP_TOP);

  // A guarded push/pop leaves sp untouched and only records the fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= SP_TOP;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (sp_write) begin
      if (sp_push) begin
        if (at_limit) stack_ovf <= 1'b1;
        else          sp        <= sp - DATA_W'(2);
      end else begin
        if (at_top)   stack_unf <= 1'b1;
        else          sp        <= sp + DATA_W'(2);
      end
    end
  end

endmodule

// File: rtl/pc_sp_unit.sv
// PC, SP, ALUOut and fetched-PC registers for the multicycle datapath.
// Latency: one edge from enable to new value; no backpressure, sequencing owned by control FSM.
module pc_sp_unit #(
  parameter int                 DATA_W   = pc_sp_unit_pkg::DATA_W,
  parameter logic [DATA_W-1:0]  RESET_PC = pc_sp_unit_pkg::RESET_PC,
  parameter logic [DATA_W-1:0]  SP_TOP   = pc_sp_unit_pkg::SP_TOP,
  parameter logic [DATA_W-1:0]  SP_LIMIT = pc_sp_unit_pkg::SP_LIMIT,
  parameter logic [DATA_W-1:0]  EXC_VEC  = pc_sp_unit_pkg::EXC_VEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic [1:0]        PCSrc,
  input  logic              PCMUX,
  input  logic              SPWrite,
  input  logic              sp_push,
  input  logic              IRWrite,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [11:0]       ir_imm12,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] fetch_pc,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic              pc_misalign
);

  import pc_sp_unit_pkg::*;

  logic              pc_en;
  logic [DATA_W-1:0] target;

  assign pc_en = PCWrite | (PCWriteCond & zero);

  // Return address from memory overrides the PCSrc selection.
  always_comb begin
    target = alu_result;
    if (PCMUX) begin
      target = mem_rdata;
    end else begin
      case (pcsrc_e'(PCSrc))
        PCSRC_ALU:    target = alu_result;
        PCSRC_ALUOUT: target = alu_out;
        PCSRC_JUMP:   target = {fetch_pc[DATA_W-1:DATA_W-3], ir_imm12, 1'b0};
        PCSRC_EXC:    target = EXC_VEC;
        default:      target = alu_result;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      alu_out     <= '0;
      fetch_pc    <= RESET_PC;
      pc_misalign <= 1'b0;
    end else begin
      alu_out     <= alu_result;
      pc_misalign <= pc_en & target[0];
      if (IRWrite) fetch_pc <= pc;
      if (pc_en)   pc       <= {target[DATA_W-1:1], 1'b0};
    end
  end

  sp_guard #(
    .DATA_W   (DATA_W),
    .SP_TOP   (SP_TOP),
    .SP_LIMIT (SP_LIMIT)
  ) u_sp_guard (
    .clk       (clk),
    .rst       (rst),
    .sp_write  (SPWrite),
    .sp_push   (sp_push),
    .sp        (sp),
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
  );

endmodule

// File: tb/tb_pc_sp_unit.sv
// Directed bench for pc_sp_unit: per-cycle model compare plus literal checkpoints.
module tb_pc_sp_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite, PCWriteCond, PCMUX, SPWrite, sp_push, IRWrite, zero;
  logic [1:0]  PCSrc;
  logic [15:0] alu_result, mem_rdata;
  logic [11:0] ir_imm12;
  logic [15:0] pc, sp, alu_out, fetch_pc;
  logic        stack_ovf, stack_unf, pc_misalign;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sp_unit dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCSrc(PCSrc), .PCMUX(PCMUX), .SPWrite(SPWrite), .sp_push(sp_push),
    .IRWrite(IRWrite), .zero(zero), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .ir_imm12(ir_imm12), .pc(pc), .sp(sp),
    .alu_out(alu_out), .fetch_pc(fetch_pc), .stack_ovf(stack_ovf),
    .stack_unf(stack_unf), .pc_misalign(pc_misalign)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: stack kept as a depth count, pc as a plain address.
  localparam int MAX_DEPTH = (16'hFFFE - 16'hF000) / 2;
  bit          m_ok = 1'b0;
  int          m_depth;
  logic [15:0] m_pc, m_alu_out, m_fetch_pc;
  bit          m_ovf, m_unf, m_mis;

  always @(posedge clk) begin
    logic [15:0] tgt;
    bit          en;
    if (rst) begin
      m_ok = 1'b1; m_depth = 0; m_pc = 16'h0000; m_alu_out = 16'h0000;
      m_fetch_pc = 16'h0000; m_ovf = 0; m_unf = 0; m_mis = 0;
    end else if (m_ok) begin
      en = PCWrite || (PCWriteCond && zero);
      if (PCMUX)            tgt = mem_rdata;
      else if (PCSrc == 0)  tgt = alu_result;
      else if (PCSrc == 1)  tgt = m_alu_out;
      else if (PCSrc == 2)  tgt = (m_fetch_pc & 16'hE000) | (16'(ir_imm12) * 2);
      else                  tgt = 16'h0010;
      m_mis = en && (tgt % 2 == 1);
      if (IRWrite) m_fetch_pc = m_pc;
      if (en) m_pc = tgt - (tgt % 2);
      m_alu_out = alu_result;
      if (SPWrite) begin
        if (sp_push) begin
          if (m_depth == MAX_DEPTH) m_ovf = 1; else m_depth++;
        end else begin
          if (m_depth == 0) m_unf = 1; else m_depth--;
        end
      end
    end
    #1;
    if (m_ok) begin
      check("pc", pc, m_pc);
      check("sp", sp, 16'hFFFE - 16'(2 * m_depth));
      check("alu_out", alu_out, m_alu_out);
      check("fetch_pc", fetch_pc, m_fetch_pc);
      check("stack_ovf", {15'd0, stack_ovf}, {15'd0, m_ovf});
      check("stack_unf", {15'd0, stack_unf}, {15'd0, m_unf});
      check("pc_misalign", {15'd0, pc_misalign}, {15'd0, m_mis});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    PCWrite = 0; PCWriteCond = 0; PCMUX = 0; SPWrite = 0; sp_push = 0;
    IRWrite = 0; zero = 0; PCSrc = 2'b00;
  endtask

  initial begin
    rst = 1; idle(); alu_result = 16'h0; mem_rdata = 16'h0; ir_imm12 = 12'h0;
    tick();
    check("reset pc", pc, 16'h0000);
    check("reset sp", sp, 16'hFFFE);
    check("reset flags", {13'd0, stack_ovf, stack_unf, pc_misalign}, 16'h0);
    rst = 0;

    // 1: fetch increment
    PCWrite = 1; alu_result = 16'h0002; tick();
    check("fetch pc", pc, 16'h0002);
    check("fetch sp", sp, 16'hFFFE);

    // 2: conditional branch through alu_out
    idle(); alu_result = 16'h0040; tick();
    check("alu_out load", alu_out, 16'h0040);
    PCWriteCond = 1; PCSrc = 2'b01; zero = 0; alu_result = 16'h0099; tick();
    check("branch not taken", pc, 16'h0002);
    alu_result = 16'h0040; tick();
    check("alu_out tracks", alu_out, 16'h0040);
    zero = 1; tick();
    check("branch taken", pc, 16'h0040);

    // 3: jump, then odd target
    idle(); PCWrite = 1; alu_result = 16'h2000; tick();
    idle(); IRWrite = 1; tick();
    check("fetch_pc capture", fetch_pc, 16'h2000);
    idle(); PCWrite = 1; PCSrc = 2'b10; ir_imm12 = 12'h7FF; tick();
    check("jump pc", pc, 16'h2FFE);
    check("jump no misalign", {15'd0, pc_misalign}, 16'h0);
    PCSrc = 2'b00; alu_result = 16'h0031; tick();
    check("odd pc", pc, 16'h0030);
    check("misalign pulse", {15'd0, pc_misalign}, 16'h1);
    idle(); tick();
    check("misalign clears", {15'd0, pc_misalign}, 16'h0);

    // exception vector
    PCWrite = 1; PCSrc = 2'b11; tick();
    check("exc pc", pc, 16'h0010);

    // 4: call / return; fetch_pc still 0x2000
    idle(); PCWrite = 1; PCSrc = 2'b10; SPWrite = 1; sp_push = 1; tick();
    check("call pc", pc, 16'h2FFE);
    check("call sp", sp, 16'hFFFC);
    PCMUX = 1; mem_rdata = 16'h0102; sp_push = 0; tick();
    check("ret pc", pc, 16'h0102);
    check("ret sp", sp, 16'hFFFE);

    // 5: bounds
    idle(); SPWrite = 1; sp_push = 0; tick();
    check("underflow sp", sp, 16'hFFFE);
    check("underflow flag", {15'd0, stack_unf}, 16'h1);
    sp_push = 1;
    for (int i = 0; i < 16'h07FF; i++) tick();
    check("full sp", sp, 16'hF000);
    check("unf sticky", {15'd0, stack_unf}, 16'h1);
    check("no ovf yet", {15'd0, stack_ovf}, 16'h0);
    tick();
    check("overflow sp", sp, 16'hF000);
    check("overflow flag", {15'd0, stack_ovf}, 16'h1);
    idle(); SPWrite = 1; sp_push = 0; tick();
    check("pop after ovf", sp, 16'hF002);
    check("ovf sticky", {15'd0, stack_ovf}, 16'h1);

    // 6: reset wins over simultaneous enables
    idle(); rst = 1; PCWrite = 1; SPWrite = 1; sp_push = 1; IRWrite = 1;
    alu_result = 16'h1235; tick();
    check("mid reset pc", pc, 16'h0000);
    check("mid reset sp", sp, 16'hFFFE);
    check("mid reset alu_out", alu_out, 16'h0000);
    check("mid reset fetch_pc", fetch_pc, 16'h0000);
    check("mid reset flags", {13'd0, stack_ovf, stack_unf, pc_misalign}, 16'h0);
    rst = 0; idle(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
